// File: rtl/systolic_array_driver.sv
// Host-side sequencer for a weight-stationary systolic array: fetches the weight and input
// matrices from word-addressed memory, runs the load/enable handshake, waits for the array
// to finish (bounded by a timeout) and writes the result matrix back to memory.
module systolic_array_driver #(
    parameter int unsigned SIZE         = 4,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned RESULT_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned TIMEOUT      = 64
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          start,
    input  logic [ADDR_WIDTH-1:0]                         w_base,
    input  logic [ADDR_WIDTH-1:0]                         x_base,
    input  logic [ADDR_WIDTH-1:0]                         y_base,
    output logic                                          busy,
    output logic                                          finish,
    output logic                                          err,
    output logic                                          mem_rd_en,
    output logic                                          mem_wr_en,
    output logic [ADDR_WIDTH-1:0]                         mem_addr,
    input  logic [DATA_WIDTH-1:0]                         mem_rdata,
    output logic [RESULT_WIDTH-1:0]                       mem_wdata,
    output logic                                          sa_load_weights,
    output logic                                          sa_enable,
    output logic [SIZE-1:0][SIZE-1:0][DATA_WIDTH-1:0]     sa_weight_data,
    output logic [SIZE-1:0][SIZE-1:0][DATA_WIDTH-1:0]     sa_input_data,
    input  logic [SIZE-1:0][SIZE-1:0][RESULT_WIDTH-1:0]   sa_output_data,
    input  logic                                          sa_done
);

    localparam int unsigned NumElem = SIZE * SIZE;
    localparam int unsigned CntW    = $clog2(NumElem + 1);
    localparam int unsigned IdxW    = (NumElem > 1) ? $clog2(NumElem) : 1;
    localparam int unsigned RunW    = $clog2(TIMEOUT + 1);

    // Read phases run one extra cycle to collect the final word; writes do not.
    localparam logic [CntW-1:0] CntLastRd = CntW'(NumElem);
    localparam logic [CntW-1:0] CntLastWr = CntW'(NumElem - 1);
    localparam logic [RunW-1:0] RunLast   = RunW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        StIdle,
        StRdW,
        StRdX,
        StLoadW,
        StGap,
        StRun,
        StWr,
        StFinish,
        StErr
    } state_e;

    state_e state_q, state_d;

    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [RunW-1:0]       run_cnt_q, run_cnt_d;
    logic [ADDR_WIDTH-1:0] w_base_q, w_base_d;
    logic [ADDR_WIDTH-1:0] x_base_q, x_base_d;
    logic [ADDR_WIDTH-1:0] y_base_q, y_base_d;
    logic                  err_q, err_d;

    // Flat row-major storage; bit layout is identical to the [SIZE][SIZE] port view.
    logic [NumElem-1:0][DATA_WIDTH-1:0]   weight_q, weight_d;
    logic [NumElem-1:0][DATA_WIDTH-1:0]   input_q, input_d;
    logic [NumElem-1:0][RESULT_WIDTH-1:0] result_q, result_d;

    // Read data lags the request by one cycle, so it lands in element cnt-1.
    logic [CntW-1:0] cnt_m1;
    logic [IdxW-1:0] rd_idx;
    logic [IdxW-1:0] wr_idx;

    assign cnt_m1 = cnt_q - CntW'(1);
    assign rd_idx = cnt_m1[IdxW-1:0];
    assign wr_idx = cnt_q[IdxW-1:0];

    assign sa_weight_data = weight_q;
    assign sa_input_data  = input_q;
    assign err            = err_q;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRdW;
                end
            end
            StRdW: begin
                if (cnt_q == CntLastRd) begin
                    state_d = StRdX;
                end
            end
            StRdX: begin
                if (cnt_q == CntLastRd) begin
                    state_d = StLoadW;
                end
            end
            StLoadW:  state_d = StGap;
            StGap:    state_d = StRun;
            StRun: begin
                if (sa_done) begin
                    state_d = StWr;
                end else if (run_cnt_q == RunLast) begin
                    state_d = StErr;
                end
            end
            StWr: begin
                if (cnt_q == CntLastWr) begin
                    state_d = StFinish;
                end
            end
            StFinish: state_d = StIdle;
            StErr:    state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Per-state outputs: memory requests and array handshake.
    always_comb begin
        busy            = (state_q != StIdle);
        finish          = 1'b0;
        mem_rd_en       = 1'b0;
        mem_wr_en       = 1'b0;
        mem_addr        = '0;
        mem_wdata       = '0;
        sa_enable       = 1'b0;
        sa_load_weights = 1'b0;
        unique case (state_q)
            StRdW: begin
                if (cnt_q != CntLastRd) begin
                    mem_rd_en = 1'b1;
                    mem_addr  = w_base_q + ADDR_WIDTH'(cnt_q);
                end
            end
            StRdX: begin
                if (cnt_q != CntLastRd) begin
                    mem_rd_en = 1'b1;
                    mem_addr  = x_base_q + ADDR_WIDTH'(cnt_q);
                end
            end
            StLoadW: begin
                sa_enable       = 1'b1;
                sa_load_weights = 1'b1;
            end
            // Enable low here gives the array a clean rising edge to start computing.
            StGap: ;
            StRun: begin
                sa_enable = 1'b1;
            end
            StWr: begin
                mem_wr_en = 1'b1;
                mem_addr  = y_base_q + ADDR_WIDTH'(cnt_q);
                mem_wdata = result_q[wr_idx];
            end
            StFinish: begin
                finish = 1'b1;
            end
            StIdle, StErr: ;
            default: ;
        endcase
    end

    // Datapath registers: counters, latched bases, matrices and error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            run_cnt_q <= '0;
            w_base_q  <= '0;
            x_base_q  <= '0;
            y_base_q  <= '0;
            err_q     <= 1'b0;
            weight_q  <= '0;
            input_q   <= '0;
            result_q  <= '0;
        end else begin
            cnt_q     <= cnt_d;
            run_cnt_q <= run_cnt_d;
            w_base_q  <= w_base_d;
            x_base_q  <= x_base_d;
            y_base_q  <= y_base_d;
            err_q     <= err_d;
            weight_q  <= weight_d;
            input_q   <= input_d;
            result_q  <= result_d;
        end
    end

    // Datapath next-state: capture read data, count phases, sample results.
    always_comb begin
        cnt_d     = cnt_q;
        run_cnt_d = run_cnt_q;
        w_base_d  = w_base_q;
        x_base_d  = x_base_q;
        y_base_d  = y_base_q;
        err_d     = err_q;
        weight_d  = weight_q;
        input_d   = input_q;
        result_d  = result_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (start) begin
                    w_base_d = w_base;
                    x_base_d = x_base;
                    y_base_d = y_base;
                    err_d    = 1'b0;
                end
            end
            StRdW: begin
                if (cnt_q != '0) begin
                    weight_d[rd_idx] = mem_rdata;
                end
                cnt_d = (cnt_q == CntLastRd) ? '0 : cnt_q + CntW'(1);
            end
            StRdX: begin
                if (cnt_q != '0) begin
                    input_d[rd_idx] = mem_rdata;
                end
                cnt_d = (cnt_q == CntLastRd) ? '0 : cnt_q + CntW'(1);
            end
            StGap: begin
                run_cnt_d = '0;
            end
            StRun: begin
                cnt_d = '0;
                if (sa_done) begin
                    result_d = sa_output_data;
                end else if (run_cnt_q == RunLast) begin
                    err_d = 1'b1;
                end else begin
                    run_cnt_d = run_cnt_q + RunW'(1);
                end
            end
            StWr: begin
                cnt_d = (cnt_q == CntLastWr) ? '0 : cnt_q + CntW'(1);
            end
            StLoadW, StFinish, StErr: ;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_systolic_array_driver.sv
// Bench for systolic_array_driver: memory model, behavioural array model, write scoreboard.
module tb_systolic_array_driver;

    localparam int N       = 4;
    localparam int NE      = N * N;
    localparam int DW      = 16;
    localparam int RW      = 32;
    localparam int AW      = 16;
    localparam int TO      = 64;
    localparam int LAT     = 8;
    localparam int T_RUN   = LAT + 1;
    localparam int LATENCY = 2 * (NE + 1) + 2 + T_RUN + NE + 1;

    typedef logic [N-1:0][N-1:0][DW-1:0] mat_d_t;
    typedef logic [N-1:0][N-1:0][RW-1:0] mat_r_t;

    typedef struct {
        logic [AW-1:0] w_base;
        logic [AW-1:0] x_base;
        logic [AW-1:0] y_base;
        logic [DW-1:0] w_first;
        logic [DW-1:0] x_first;
        logic [DW-1:0] exp_w12;
        logic [DW-1:0] exp_x33;
        bit            pulse;
    } job_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [RW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] w_base, x_base, y_base;
    logic          busy, finish, err;
    logic          mem_rd_en, mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] rdata_q = '0;
    logic [RW-1:0] mem_wdata;
    logic          sa_load_weights, sa_enable;
    mat_d_t        sa_weight_data, sa_input_data;
    mat_r_t        res_q = '0;
    logic          done_q = 1'b0;

    systolic_array_driver #(
        .SIZE(N), .DATA_WIDTH(DW), .RESULT_WIDTH(RW), .ADDR_WIDTH(AW), .TIMEOUT(TO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .w_base         (w_base),
        .x_base         (x_base),
        .y_base         (y_base),
        .busy           (busy),
        .finish         (finish),
        .err            (err),
        .mem_rd_en      (mem_rd_en),
        .mem_wr_en      (mem_wr_en),
        .mem_addr       (mem_addr),
        .mem_rdata      (rdata_q),
        .mem_wdata      (mem_wdata),
        .sa_load_weights(sa_load_weights),
        .sa_enable      (sa_enable),
        .sa_weight_data (sa_weight_data),
        .sa_input_data  (sa_input_data),
        .sa_output_data (res_q),
        .sa_done        (done_q)
    );

    always #5 clk = ~clk;

    // Memory: read data valid the cycle after the request.
    logic [DW-1:0] mem [0:65535];
    always @(posedge clk) begin
        if (mem_rd_en) rdata_q <= mem[mem_addr];
    end

    // Array model: latch weights on load, start on enable rising edge, done after LAT cycles.
    logic   en_prev = 1'b0;
    logic   running = 1'b0;
    logic   force_off = 1'b0;
    int     mcnt = 0;
    int     model_starts = 0;
    mat_d_t w_lat = '0;

    function automatic mat_r_t compute(input mat_d_t w, input mat_d_t x);
        mat_r_t r;
        logic [RW-1:0] acc;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                acc = '0;
                for (int k = 0; k < N; k++) acc += 32'(x[i][k]) * 32'(w[k][j]);
                r[i][j] = acc;
            end
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            running <= 1'b0;
            done_q  <= 1'b0;
            en_prev <= 1'b0;
        end else begin
            en_prev <= sa_enable;
            if (sa_enable && sa_load_weights) w_lat <= sa_weight_data;
            if (!sa_enable) begin
                running <= 1'b0;
                done_q  <= 1'b0;
            end else if (!sa_load_weights && !en_prev) begin
                running      <= 1'b1;
                mcnt         <= 1;
                model_starts <= model_starts + 1;
                res_q        <= compute(w_lat, sa_input_data);
            end else if (running) begin
                mcnt <= mcnt + 1;
                if (mcnt == LAT - 1 && !force_off) done_q <= 1'b1;
            end
        end
    end

    int checks = 0;
    int errors = 0;
    wr_t sb[$];
    logic [AW-1:0] rd_addrs[$];
    int wr_cnt = 0, ld_cycles = 0, gap_cnt = 0, run_cycles = 0, finish_cnt = 0, both_viol = 0;
    bit prev_ld = 1'b0;
    int ld0, gap0, run0, st0, f0, wr0, rd0;
    int busy_cycles;
    bit seen;
    job_t tbl[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock and sample everything 1ns after the edge.
    task automatic tick();
        wr_t e;
        @(posedge clk);
        #1;
        if (mem_rd_en) rd_addrs.push_back(mem_addr);
        if (mem_rd_en && mem_wr_en) both_viol++;
        if (mem_wr_en) begin
            wr_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got write to %0h expected none", mem_addr);
            end else begin
                e = sb.pop_front();
                check("wr_addr", 64'(mem_addr), 64'(e.addr));
                check("wr_data", 64'(mem_wdata), 64'(e.data));
            end
        end
        if (sa_enable && sa_load_weights) ld_cycles++;
        if (prev_ld && !sa_enable && !sa_load_weights) gap_cnt++;
        prev_ld = sa_enable && sa_load_weights;
        if (sa_enable && !sa_load_weights) run_cycles++;
        if (finish) finish_cnt++;
    endtask

    task automatic snapshot();
        ld0 = ld_cycles; gap0 = gap_cnt; run0 = run_cycles; st0 = model_starts;
        f0 = finish_cnt; wr0 = wr_cnt; rd0 = rd_addrs.size();
    endtask

    task automatic setup_job(input job_t j, input bit push);
        logic [RW-1:0] acc;
        logic [DW-1:0] xv, wv;
        wr_t e;
        for (int k = 0; k < NE; k++) begin
            mem[j.w_base + 16'(k)] = j.w_first + 16'(k);
            mem[j.x_base + 16'(k)] = j.x_first + 16'(k);
        end
        if (push) begin
            for (int i = 0; i < N; i++) begin
                for (int c = 0; c < N; c++) begin
                    acc = '0;
                    for (int k = 0; k < N; k++) begin
                        xv = j.x_first + 16'(i * N + k);
                        wv = j.w_first + 16'(k * N + c);
                        acc += 32'(xv) * 32'(wv);
                    end
                    e.addr = j.y_base + 16'(i * N + c);
                    e.data = acc;
                    sb.push_back(e);
                end
            end
        end
        w_base = j.w_base;
        x_base = j.x_base;
        y_base = j.y_base;
        snapshot();
    endtask

    task automatic kick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_job(input job_t j);
        logic [AW-1:0] ea;
        setup_job(j, 1'b1);
        kick();
        check("err_clear_on_start", 64'(err), 64'(0));
        busy_cycles = 0;
        seen = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            if (busy) busy_cycles++;
            if (finish) seen = 1'b1;
            else begin
                start = j.pulse && (busy_cycles == 20 || busy_cycles == 50);
                tick();
            end
        end
        start = 1'b0;
        check("finish_seen", 64'(seen), 64'(1));
        check("latency", 64'(busy_cycles), 64'(LATENCY));
        check("w12", 64'(sa_weight_data[1][2]), 64'(j.exp_w12));
        check("x33", 64'(sa_input_data[3][3]), 64'(j.exp_x33));
        check("loadw_cycles", 64'(ld_cycles - ld0), 64'(1));
        check("gap_cycles", 64'(gap_cnt - gap0), 64'(1));
        check("run_cycles", 64'(run_cycles - run0), 64'(T_RUN));
        check("model_starts", 64'(model_starts - st0), 64'(1));
        tick();
        check("busy_after_finish", 64'(busy), 64'(0));
        check("finish_one_cycle", 64'(finish), 64'(0));
        repeat (4) tick();
        check("finish_count", 64'(finish_cnt - f0), 64'(1));
        check("idle_stays_idle", 64'(busy), 64'(0));
        check("write_count", 64'(wr_cnt - wr0), 64'(NE));
        check("sb_empty", 64'(sb.size()), 64'(0));
        check("w12_hold", 64'(sa_weight_data[1][2]), 64'(j.exp_w12));
        check("read_count", 64'(rd_addrs.size() - rd0), 64'(2 * NE));
        if (rd_addrs.size() - rd0 == 2 * NE) begin
            for (int k = 0; k < 2 * NE; k++) begin
                ea = (k < NE) ? j.w_base + 16'(k) : j.x_base + 16'(k - NE);
                check("read_addr", 64'(rd_addrs[rd0 + k]), 64'(ea));
            end
        end
    endtask

    initial begin
        tbl[0] = '{16'h0000, 16'h0040, 16'h0080, 16'd1,     16'd17,    16'd7,     16'd32,    1'b0};
        tbl[1] = '{16'h0100, 16'h0200, 16'h0300, 16'd100,   16'd5000,  16'd106,   16'd5015,  1'b1};
        tbl[2] = '{16'hFFFA, 16'h0010, 16'h0020, 16'd3,     16'd9,     16'd9,     16'd24,    1'b0};
        tbl[3] = '{16'h0500, 16'h0600, 16'hFFFC, 16'h8000,  16'hFFF0,  16'h8006,  16'hFFFF,  1'b0};

        reset = 1'b1;
        start = 1'b0;
        w_base = '0;
        x_base = '0;
        y_base = '0;
        #12;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_finish", 64'(finish), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_rd_en", 64'(mem_rd_en), 64'(0));
        check("rst_wr_en", 64'(mem_wr_en), 64'(0));
        check("rst_addr", 64'(mem_addr), 64'(0));
        check("rst_wdata", 64'(mem_wdata), 64'(0));
        check("rst_enable", 64'(sa_enable), 64'(0));
        check("rst_load", 64'(sa_load_weights), 64'(0));
        check("rst_weights", 64'(|sa_weight_data), 64'(0));
        check("rst_inputs", 64'(|sa_input_data), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Table jobs: basic, start pulsed mid-job, address wrap.
        for (int t = 0; t < 3; t++) begin
            run_job(tbl[t]);
            if (t == 2) begin
                check("wrap_addr5", 64'(rd_addrs[rd0 + 5]), 64'(16'hFFFF));
                check("wrap_addr6", 64'(rd_addrs[rd0 + 6]), 64'(16'h0000));
                check("wrap_addr15", 64'(rd_addrs[rd0 + 15]), 64'(16'h0009));
            end
        end

        // Timeout: array never reports done.
        force_off = 1'b1;
        setup_job(tbl[3], 1'b0);
        kick();
        busy_cycles = 0;
        seen = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            if (busy) busy_cycles++;
            if (err) seen = 1'b1;
            else tick();
        end
        check("timeout_err", 64'(seen), 64'(1));
        check("timeout_cycles", 64'(busy_cycles), 64'(2 * (NE + 1) + 2 + TO + 1));
        check("timeout_run_cycles", 64'(run_cycles - run0), 64'(TO));
        tick();
        check("timeout_busy", 64'(busy), 64'(0));
        check("timeout_err_hold", 64'(err), 64'(1));
        repeat (5) tick();
        check("timeout_err_sticky", 64'(err), 64'(1));
        check("timeout_no_writes", 64'(wr_cnt - wr0), 64'(0));
        check("timeout_no_finish", 64'(finish_cnt - f0), 64'(0));
        force_off = 1'b0;

        // Next accepted start clears err.
        run_job(tbl[3]);

        // Reset in the middle of the write phase.
        setup_job(tbl[0], 1'b1);
        kick();
        for (int c = 0; c < 300 && (wr_cnt - wr0) < 5; c++) tick();
        check("writes_before_reset", 64'(wr_cnt - wr0), 64'(5));
        #2;
        reset = 1'b1;
        sb.delete();
        #1;
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_wr_en", 64'(mem_wr_en), 64'(0));
        check("mid_rst_enable", 64'(sa_enable), 64'(0));
        check("mid_rst_weights", 64'(|sa_weight_data), 64'(0));
        tick();
        check("mid_rst_wr_en_next", 64'(mem_wr_en), 64'(0));
        check("no_partial_write", 64'(wr_cnt - wr0), 64'(5));
        @(negedge clk);
        reset = 1'b0;
        tick();
        run_job(tbl[0]);

        check("rd_wr_exclusive", 64'(both_viol), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
